// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-outstanding request decoder to one synchronous RAM and NUM_PERIPH peripheral regions
module mem_bus_ctrl #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int RAM_WORDS   = 1024,
    parameter int NUM_PERIPH  = 2,
    parameter int PERIPH_SPAN = 16,
    parameter int PERIPH_WAIT = 1
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                req_valid,
    input  logic                                                req_we,
    input  logic [ADDR_W-1:0]                                   req_addr,
    input  logic [DATA_W-1:0]                                   req_wdata,
    output logic                                                req_ready,
    output logic                                                rsp_valid,
    output logic [DATA_W-1:0]                                   rsp_rdata,
    output logic                                                rsp_err,
    output logic                                                ram_we,
    output logic [((RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1)-1:0]     ram_addr,
    output logic [DATA_W-1:0]                                   ram_wdata,
    input  logic [DATA_W-1:0]                                   ram_rdata,
    output logic [NUM_PERIPH-1:0]                               per_sel,
    output logic                                                per_we,
    output logic [((PERIPH_SPAN > 1) ? $clog2(PERIPH_SPAN) : 1)-1:0] per_addr,
    output logic [DATA_W-1:0]                                   per_wdata,
    input  logic [NUM_PERIPH*DATA_W-1:0]                        per_rdata
);

    localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          PER_AW    = (PERIPH_SPAN > 1) ? $clog2(PERIPH_SPAN) : 1;
    localparam int          SPAN_SH   = $clog2(PERIPH_SPAN);
    localparam int          IDX_W     = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam logic [31:0] RAM_END   = 32'(RAM_WORDS);
    localparam logic [31:0] PER_WORDS = 32'(NUM_PERIPH * PERIPH_SPAN);
    localparam logic [3:0]  WAIT_INIT = 4'(PERIPH_WAIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAM_ACC = 3'd1,
        RAM_CAP = 3'd2,
        PER_ACC = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                req_ready_q, req_ready_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [NUM_PERIPH-1:0] per_sel_q, per_sel_d;
    logic                per_we_q, per_we_d;
    logic [PER_AW-1:0]   per_addr_q, per_addr_d;
    logic [DATA_W-1:0]   per_wdata_q, per_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]           addr_ext;
    logic [31:0]           per_off;
    logic                  hit_ram;
    logic                  hit_per;
    logic [IDX_W-1:0]      hit_idx;
    logic [NUM_PERIPH-1:0] hit_onehot;
    logic [DATA_W-1:0]     per_rdata_sel;

    // Address decode of the incoming request: RAM, peripheral k, or unmapped
    always_comb begin
        addr_ext = 32'(req_addr);
        per_off  = addr_ext - RAM_END;
        hit_ram  = addr_ext < RAM_END;
        hit_per  = !hit_ram && (per_off < PER_WORDS);
        hit_idx  = IDX_W'(per_off >> SPAN_SH);
        for (int k = 0; k < NUM_PERIPH; k++) begin
            hit_onehot[k] = (hit_idx == IDX_W'(k));
        end
    end

    // Read-data slice of the peripheral latched at acceptance
    always_comb begin
        per_rdata_sel = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                per_rdata_sel = per_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output computation; strobes default low every cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        req_ready_d = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        per_sel_d   = '0;
        per_we_d    = 1'b0;
        per_addr_d  = per_addr_q;
        per_wdata_d = per_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    if (hit_ram) begin
                        state_d     = RAM_ACC;
                        ram_we_d    = req_we;
                        ram_addr_d  = RAM_AW'(req_addr);
                        ram_wdata_d = req_wdata;
                    end else if (hit_per) begin
                        state_d     = PER_ACC;
                        cnt_d       = WAIT_INIT;
                        idx_d       = hit_idx;
                        per_sel_d   = hit_onehot;
                        per_addr_d  = PER_AW'(per_off);
                        per_wdata_d = req_wdata;
                        // With no wait states the single access cycle is also the last one
                        per_we_d    = req_we && (WAIT_INIT == 4'd0);
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RAM_ACC: begin
                state_d = RAM_CAP;
            end
            RAM_CAP: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? '0 : ram_rdata;
            end
            PER_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : per_rdata_sel;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    per_sel_d = per_sel_q;
                    per_we_d  = we_q && (cnt_q == 4'd1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and aborts any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            per_sel_q   <= '0;
            per_we_q    <= 1'b0;
            per_addr_q  <= '0;
            per_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            req_ready_q <= req_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            per_sel_q   <= per_sel_d;
            per_we_q    <= per_we_d;
            per_addr_q  <= per_addr_d;
            per_wdata_q <= per_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign per_sel   = per_sel_q;
    assign per_we    = per_we_q;
    assign per_addr  = per_addr_q;
    assign per_wdata = per_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - vector table, random transactions against a region/latency model, reset-abort and back-to-back sequences
module tb_mem_bus_ctrl;

    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 32;
    localparam int RAM_WORDS   = 1024;
    localparam int NUM_PERIPH  = 2;
    localparam int PERIPH_SPAN = 16;
    localparam int PW          = 3;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         req_valid = 1'b0;
    logic                         req_we = 1'b0;
    logic [ADDR_W-1:0]            req_addr = '0;
    logic [DATA_W-1:0]            req_wdata = '0;
    logic                         req_ready;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic                         ram_we;
    logic [9:0]                   ram_addr;
    logic [DATA_W-1:0]            ram_wdata;
    logic [DATA_W-1:0]            ram_rdata;
    logic [NUM_PERIPH-1:0]        per_sel;
    logic                         per_we;
    logic [3:0]                   per_addr;
    logic [DATA_W-1:0]            per_wdata;
    logic [NUM_PERIPH*DATA_W-1:0] per_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem     [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];

    mem_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_WORDS(RAM_WORDS),
        .NUM_PERIPH(NUM_PERIPH), .PERIPH_SPAN(PERIPH_SPAN), .PERIPH_WAIT(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .per_sel(per_sel), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_rdata(per_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM device: read data appears one cycle after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // 0 = RAM, 1 = peripheral, 2 = unmapped
    function automatic int region_of(input int a);
        if (a < RAM_WORDS) return 0;
        if (a < RAM_WORDS + NUM_PERIPH * PERIPH_SPAN) return 1;
        return 2;
    endfunction

    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                           input logic [31:0] pd, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rd, input string tag);
        int a, rgn, k, lat, n_ramwe, n_perwe, n_sel, n_bad;
        bit got;
        logic [NUM_PERIPH-1:0] exp_sel;
        a       = int'(addr);
        rgn     = region_of(a);
        k       = (rgn == 1) ? (a - RAM_WORDS) / PERIPH_SPAN : 0;
        exp_sel = (rgn == 1) ? NUM_PERIPH'(1 << k) : '0;
        for (int p = 0; p < NUM_PERIPH; p++) begin
            per_rdata[p*DATA_W +: DATA_W] = (p == k) ? pd : ~pd;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, " accept"}, int'(got), 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        lat = -1; n_ramwe = 0; n_perwe = 0; n_sel = 0; n_bad = 0;
        for (int n = 1; n <= 40; n++) begin
            if (ram_we) begin
                n_ramwe++;
                if (ram_addr !== 10'(a) || ram_wdata !== wd) n_bad++;
            end
            if (n == 1 && rgn == 0 && ram_addr !== 10'(a)) n_bad++;
            if (per_sel != '0) begin
                n_sel++;
                if (per_sel !== exp_sel || per_addr !== 4'(a - RAM_WORDS) || per_wdata !== wd) n_bad++;
            end
            if (per_we) begin
                n_perwe++;
                if (per_sel !== exp_sel) n_bad++;
            end
            if (rsp_err && !rsp_valid) n_bad++;
            if (req_ready) n_bad++;
            if (rsp_valid) begin lat = n; break; end
            @(negedge clk);
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rsp_err"}, int'(rsp_err), int'(exp_err));
        check({tag, " rsp_rdata"}, int'(rsp_rdata), int'(exp_rd));
        check({tag, " ram_we cycles"}, n_ramwe, (rgn == 0 && we) ? 1 : 0);
        check({tag, " per_we cycles"}, n_perwe, (rgn == 1 && we) ? 1 : 0);
        check({tag, " per_sel cycles"}, n_sel, (rgn == 1) ? PW + 1 : 0);
        check({tag, " bad strobe/addr cycles"}, n_bad, 0);
        @(negedge clk);
        check({tag, " rsp pulse ends"}, int'({rsp_valid, rsp_err}), 0);
        check({tag, " ready after resp"}, int'(req_ready), 1);
    endtask

    task automatic model_txn(input logic we, input int a, input string tag);
        logic [31:0] wd, pd, rd;
        int rgn, lat;
        wd  = $urandom;
        pd  = $urandom;
        rgn = region_of(a);
        lat = (rgn == 0) ? 3 : (rgn == 1) ? PW + 2 : 1;
        rd  = '0;
        if (rgn == 0 && !we) rd = ref_mem[a];
        if (rgn == 1 && !we) rd = pd;
        if (rgn == 0 && we) ref_mem[a] = wd;
        run_txn(we, ADDR_W'(a), wd, pd, lat, rgn == 2, rd, tag);
    endtask

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [31:0] pd;
        int          lat;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int acc [4];
        int nacc, nrsp, n_rsp_after;
        logic [31:0] exp5;

        vecs[0] = '{1'b1, 11'd5,    32'h12345678, 32'h0,        3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 11'd5,    32'h0,        32'h0,        3, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 11'd1042, 32'h0,        32'hA5A5A5A5, 5, 1'b0, 32'hA5A5A5A5};
        vecs[3] = '{1'b1, 11'd1024, 32'hFF,       32'h0,        5, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 11'd2047, 32'h0,        32'h0,        1, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 11'd1023, 32'hCAFEBABE, 32'h0,        3, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 11'd1023, 32'h0,        32'h0,        3, 1'b0, 32'hCAFEBABE};
        vecs[7] = '{1'b0, 11'd1055, 32'h0,        32'h3C3C1234, 5, 1'b0, 32'h3C3C1234};
        vecs[8] = '{1'b0, 11'd1056, 32'h0,        32'h0,        1, 1'b1, 32'h0};
        vecs[9] = '{1'b1, 11'd1039, 32'h77,       32'h0,        5, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset req_ready", int'(req_ready), 0);
        check("reset rsp", int'({rsp_valid, rsp_err}), 0);
        check("reset rsp_rdata", int'(rsp_rdata), 0);
        check("reset strobes", int'({ram_we, per_we, per_sel}), 0);
        check("reset ram_addr", int'(ram_addr), 0);
        check("reset ram_wdata", int'(ram_wdata), 0);
        check("reset per_addr", int'(per_addr), 0);
        check("reset per_wdata", int'(per_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset release", int'(req_ready), 1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].pd,
                    vecs[i].lat, vecs[i].err, vecs[i].rd, $sformatf("vec%0d", i));
        end

        // Seed a small RAM window, then random traffic against the model
        for (int i = 0; i < 16; i++) model_txn(1'b1, i, $sformatf("init%0d", i));
        for (int i = 0; i < 60; i++) begin
            int sel, a;
            logic we;
            sel = $urandom_range(0, 2);
            we  = 1'($urandom);
            if (sel == 0)      a = $urandom_range(0, 15);
            else if (sel == 1) a = $urandom_range(1024, 1055);
            else               a = $urandom_range(0, 2047);
            if (a < RAM_WORDS && a > 15) we = 1'b1;
            model_txn(we, a, $sformatf("rnd%0d", i));
        end

        // Back-to-back RAM reads with req_valid held high
        exp5 = ref_mem[5];
        nacc = 0; nrsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd5;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) begin
                nrsp++;
                check("b2b rsp_rdata", int'(rsp_rdata), int'(exp5));
            end
            if (req_valid && req_ready && nacc < 4) begin
                acc[nacc] = c;
                nacc++;
            end
            @(negedge clk);
            if (nacc >= 3) req_valid = 1'b0;
        end
        check("b2b acceptances", nacc, 3);
        if (nacc >= 3) begin
            check("b2b spacing 0-1", acc[1] - acc[0], 4);
            check("b2b spacing 1-2", acc[2] - acc[1], 4);
        end
        check("b2b rsp pulses", nrsp, 3);

        // Reset during the last PER_ACC cycle of a write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd1024; req_wdata = 32'hAA;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (PW) @(negedge clk);
        check("abort per_we before reset", int'(per_we), 1);
        rst_n = 1'b0;
        #1;
        check("abort per_we after reset", int'(per_we), 0);
        check("abort per_sel after reset", int'(per_sel), 0);
        check("abort rsp_valid in reset", int'(rsp_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_rsp_after = 0;
        @(negedge clk);
        check("abort ready after release", int'(req_ready), 1);
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) n_rsp_after++;
            @(negedge clk);
        end
        check("abort no response", n_rsp_after, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11: word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width.
REQ-003 The block SHALL have parameter RAM_WORDS, default 1024: RAM region size, addresses 0..RAM_WORDS-1.
REQ-004 The block SHALL have parameter NUM_PERIPH, default 2, range 1..8: number of peripheral regions.
REQ-005 The block SHALL have parameter PERIPH_SPAN, default 16, power of 2: words per peripheral region.
REQ-006 The block SHALL have parameter PERIPH_WAIT, default 1, range 0..15: extra peripheral access cycles.
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-008 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_wdata, in, DATA_W: write data.
- req_ready, out, 1: request accepted when high together with req_valid.
- rsp_valid, out, 1: one-cycle response pulse.
- rsp_rdata, out, DATA_W: read data, registered.
- rsp_err, out, 1: unmapped access, valid with rsp_valid.
- ram_we, out, 1: RAM write enable.
- ram_addr, out, log2(RAM_WORDS): RAM address.
- ram_wdata, out, DATA_W: RAM write data.
- ram_rdata, in, DATA_W: synchronous RAM read data, valid one cycle after address.
- per_sel, out, NUM_PERIPH: one-hot peripheral select.
- per_we, out, 1: peripheral write strobe.
- per_addr, out, log2(PERIPH_SPAN): offset within the peripheral region.
- per_wdata, out, DATA_W: peripheral write data.
- per_rdata, in, NUM_PERIPH*DATA_W: combinational read data, peripheral k at bits [k*DATA_W +: DATA_W].

Function
REQ-009 Address decode SHALL be: addr < RAM_WORDS selects RAM; RAM_WORDS <= addr < RAM_WORDS + NUM_PERIPH*PERIPH_SPAN selects peripheral k = (addr-RAM_WORDS)/PERIPH_SPAN; any other address is unmapped.
REQ-010 The FSM SHALL have the states IDLE, RAM_ACC, RAM_CAP, PER_ACC and RESP.
REQ-011 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1, and addr, we and wdata are latched on that edge.
REQ-012 IDLE SHALL transition on acceptance as follows: RAM goes to RAM_ACC; a peripheral goes to PER_ACC with the wait counter loaded to PERIPH_WAIT; unmapped goes to RESP.
REQ-013 In RAM_ACC the block SHALL drive ram_addr and ram_wdata from the latched request for exactly 1 cycle, with ram_we equal to the latched we, then go to RAM_CAP.
REQ-014 In RAM_CAP the block SHALL load rsp_rdata from ram_rdata for a read, or 0 for a write, then go to RESP; RAM latency from acceptance edge to rsp_valid cycle is 3 cycles.
REQ-015 In PER_ACC the block SHALL hold per_sel[k], per_addr and per_wdata for PERIPH_WAIT+1 cycles; the counter decrements each cycle, and the last cycle is count==0.
REQ-016 per_we SHALL be high only in the last PER_ACC cycle of a write; on that edge rsp_rdata loads per_rdata slice k for a read, or 0 for a write; next state is RESP.
REQ-017 RESP SHALL last exactly 1 cycle with rsp_valid=1, then go to IDLE; there is no response backpressure.
REQ-018 An unmapped access SHALL give rsp_err=1 and rsp_rdata=0, assert no ram_we, per_we or per_sel, and have a latency of 1 cycle.
REQ-019 Outside their access states, ram_we, per_we and per_sel SHALL be 0; rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-020 At most one request SHALL be outstanding; req_valid held high back-to-back is accepted again in the IDLE cycle after RESP.

Reset
REQ-021 While rst_n=0 the FSM SHALL be in IDLE, and req_ready, rsp_valid, rsp_err, rsp_rdata, ram_we, per_we, per_sel, ram_addr, ram_wdata, per_addr, per_wdata and the counter SHALL be 0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately (ram_we/per_we drop asynchronously) and no response SHALL be issued for it.
REQ-023 req_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-024 RAM write 0x12345678 to addr 5, then read addr 5 -> write gives ram_we=1 for 1 cycle and an ack with rsp_rdata=0, rsp_err=0; read gives rsp_rdata=0x12345678 exactly 3 cycles after acceptance.
REQ-025 PERIPH_WAIT=3, read addr 1024+16+2 with per_rdata[1]=0xA5A5A5A5 -> per_sel=2'b10 and per_addr=2 for 4 cycles, then rsp_rdata=0xA5A5A5A5 at acceptance+5.
REQ-026 Write to addr 1024 with data 0xFF -> per_we high in exactly 1 cycle with per_sel=2'b01 and per_wdata=0xFF; ram_we stays 0 throughout.
REQ-027 Read addr 2047 (unmapped) -> rsp_valid and rsp_err both high at acceptance+1, rsp_rdata=0, no strobes asserted.
REQ-028 rst_n pulled low during PER_ACC of a write -> per_we and per_sel are 0 immediately, no rsp_valid is issued, and req_ready=1 the cycle after release.
REQ-029 req_valid held high for 3 RAM reads -> acceptances occur 4 cycles apart, with exactly 3 rsp_valid pulses.
